// File: rtl/cursor_uart_rx.sv
// Cursor-link UART receiver (8N1) and 5-byte packet decoder with checksum check.
// Optional inter-byte timeout enabled by defining CURSOR_RX_TIMEOUT_EN.
module cursor_uart_rx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              pkt_valid,
    output logic [1:0]        buttons,
    output logic signed [7:0] dx,
    output logic signed [7:0] dy,
    output logic              frame_err,
    output logic              chk_err,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;
    typedef enum logic [2:0] {WAIT_SYNC, GET_BTN, GET_DX, GET_DY, GET_CHK} pkt_state_t;

    bit_state_t       bit_state, bit_nxt;
    pkt_state_t       pkt_state, pkt_nxt;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       rx_byte;
    logic             byte_done;
    logic [7:0]       hold_btn, hold_dx, hold_dy;
    logic             start_edge, tick, load_out, chk_bad, timeout_hit;

    // NOTE: the synchroniser resets to the idle line level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;
    assign tick       = (bit_state == START) ? (clk_cnt == HALF_M1) : (clk_cnt == FULL_M1);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        bit_nxt = bit_state;
        case (bit_state)
            IDLE:  if (start_edge) bit_nxt = START;
            START: if (tick) bit_nxt = rx_sync ? IDLE : DATA;
            DATA:  if (tick && bit_cnt == 3'd7) bit_nxt = STOP;
            STOP:  if (tick) bit_nxt = IDLE;
            default: bit_nxt = IDLE;
        endcase
    end

    // NOTE: all state and datapath registers use non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_state <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            rx_byte   <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            bit_state <= bit_nxt;
            clk_cnt   <= (bit_state == IDLE || tick) ? '0 : clk_cnt + 1'b1;
            if (bit_state == IDLE)
                bit_cnt <= '0;
            else if (bit_state == DATA && tick)
                bit_cnt <= bit_cnt + 3'd1;
            if (bit_state == DATA && tick)
                rx_byte <= {rx_sync, rx_byte[7:1]};
            byte_done <= (bit_state == STOP) && tick && rx_sync;
            frame_err <= (bit_state == STOP) && tick && !rx_sync;
        end
    end

`ifdef CURSOR_RX_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT);
    logic [TO_W-1:0] to_cnt;
    logic            to_run;

    // Only idle line time between bytes of a partial packet counts toward the timeout.
    assign to_run      = (pkt_state != WAIT_SYNC) && (bit_state == IDLE);
    assign timeout_hit = to_run && (to_cnt == TO_W'(TO_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (start_edge || pkt_state == WAIT_SYNC || timeout_hit)
                to_cnt <= '0;
            else if (to_run)
                to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        pkt_nxt  = pkt_state;
        load_out = 1'b0;
        chk_bad  = 1'b0;
        if (frame_err || timeout_hit) begin
            pkt_nxt = WAIT_SYNC;
        end else if (byte_done) begin
            case (pkt_state)
                WAIT_SYNC: if (rx_byte == SYNC_BYTE) pkt_nxt = GET_BTN;
                GET_BTN:   pkt_nxt = GET_DX;
                GET_DX:    pkt_nxt = GET_DY;
                GET_DY:    pkt_nxt = GET_CHK;
                GET_CHK: begin
                    if (rx_byte == (hold_btn ^ hold_dx ^ hold_dy))
                        load_out = 1'b1;
                    else
                        chk_bad = 1'b1;
                    pkt_nxt = WAIT_SYNC;
                end
                default:   pkt_nxt = WAIT_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_state <= WAIT_SYNC;
            hold_btn  <= '0;
            hold_dx   <= '0;
            hold_dy   <= '0;
            pkt_valid <= 1'b0;
            chk_err   <= 1'b0;
            buttons   <= '0;
            dx        <= '0;
            dy        <= '0;
        end else begin
            pkt_state <= pkt_nxt;
            pkt_valid <= load_out;
            chk_err   <= chk_bad;
            if (byte_done && pkt_state == GET_BTN) hold_btn <= rx_byte;
            if (byte_done && pkt_state == GET_DX)  hold_dx  <= rx_byte;
            if (byte_done && pkt_state == GET_DY)  hold_dy  <= rx_byte;
            if (load_out) begin
                buttons <= hold_btn[1:0];
                dx      <= hold_dx;
                dy      <= hold_dy;
            end
        end
    end

endmodule

// File: tb/tb_cursor_uart_rx.sv
// Directed self-checking bench for cursor_uart_rx at CLKS_PER_BIT=16.
module tb_cursor_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       pkt_valid, frame_err, chk_err, timeout_err;
    logic [1:0] buttons;
    logic [7:0] dx, dy;

    cursor_uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(20)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .pkt_valid(pkt_valid), .buttons(buttons),
        .dx(dx), .dy(dy), .frame_err(frame_err), .chk_err(chk_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Pulse monitor, sampled on the falling edge away from register updates.
    int pv_cnt = 0, fe_cnt = 0, ce_cnt = 0, to_cnt = 0, overlap_cnt = 0;
    logic [1:0] log_btn [16];
    logic [7:0] log_dx  [16];
    logic [7:0] log_dy  [16];

    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_valid) begin
                if (pv_cnt < 16) begin
                    log_btn[pv_cnt] = buttons;
                    log_dx[pv_cnt]  = dx;
                    log_dy[pv_cnt]  = dy;
                end
                pv_cnt++;
            end
            if (frame_err)   fe_cnt++;
            if (chk_err)     ce_cnt++;
            if (timeout_err) to_cnt++;
            if (int'(pkt_valid) + int'(frame_err) + int'(chk_err) > 1) overlap_cnt++;
        end
    end

    int pv0, fe0, ce0, to0;

    task automatic snap();
        pv0 = pv_cnt; fe0 = fe_cnt; ce0 = ce_cnt; to0 = to_cnt;
    endtask

    task automatic check_pulses(input string tag, input int pv, input int fe, input int ce, input int to);
        check({tag, ".pkt_valid"},   pv_cnt - pv0, pv);
        check({tag, ".frame_err"},   fe_cnt - fe0, fe);
        check({tag, ".chk_err"},     ce_cnt - ce0, ce);
        check({tag, ".timeout_err"}, to_cnt - to0, to);
    endtask

    task automatic check_fields(input string tag, input logic [1:0] b, input logic [7:0] x, input logic [7:0] y);
        check({tag, ".buttons"}, buttons, b);
        check({tag, ".dx"}, dx, x);
        check({tag, ".dy"}, dy, y);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] b0, b1, b2, b3, b4);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
        send_byte(b4, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset.pkt_valid", pkt_valid, 0);
        check("reset.frame_err", frame_err, 0);
        check("reset.chk_err", chk_err, 0);
        check("reset.timeout_err", timeout_err, 0);
        check_fields("reset", 2'd0, 8'h00, 8'h00);
        rst_n = 1'b1;
        idle_bits(2);

        // 1: good packet, checksum 01^05^FB = FF
        snap();
        send_pkt(8'hA5, 8'h01, 8'h05, 8'hFB, 8'hFF);
        idle_bits(3);
        check_pulses("t1", 1, 0, 0, 0);
        check_fields("t1", 2'b01, 8'h05, 8'hFB);

        // 2: bad checksum (good would be 32), outputs hold
        snap();
        send_pkt(8'hA5, 8'h02, 8'h10, 8'h20, 8'h00);
        idle_bits(3);
        check_pulses("t2", 0, 0, 1, 0);
        check_fields("t2", 2'b01, 8'h05, 8'hFB);

        // 3: framing error on DX byte, then good packet 02^F0^0F = FD
        snap();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h05, 1'b0);
        idle_bits(2);
        send_pkt(8'hA5, 8'h02, 8'hF0, 8'h0F, 8'hFD);
        idle_bits(3);
        check_pulses("t3", 1, 1, 0, 0);
        check_fields("t3", 2'b10, 8'hF0, 8'h0F);

        // 4: garbage bytes before a good packet, 03^7F^80 = FC
        snap();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h13, 1'b1);
        send_pkt(8'hA5, 8'h03, 8'h7F, 8'h80, 8'hFC);
        idle_bits(3);
        check_pulses("t4", 1, 0, 0, 0);
        check_fields("t4", 2'b11, 8'h7F, 8'h80);

        // 5: 4-cycle glitch, then two back-to-back packets (00^11^22=33, 02^FE^01=FD)
        snap();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(3);
        send_pkt(8'hA5, 8'h00, 8'h11, 8'h22, 8'h33);
        send_pkt(8'hA5, 8'h02, 8'hFE, 8'h01, 8'hFD);
        idle_bits(3);
        check_pulses("t5", 2, 0, 0, 0);
        if (pv_cnt - pv0 == 2 && pv0 < 16) begin
            check("t5.first_buttons", log_btn[pv0], 2'b00);
            check("t5.first_dx", log_dx[pv0], 8'h11);
            check("t5.first_dy", log_dy[pv0], 8'h22);
        end
        check_fields("t5", 2'b10, 8'hFE, 8'h01);

        // 6: stalled partial packet, then a good packet 02^03^04 = 05
        snap();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        idle_bits(25);
        send_pkt(8'hA5, 8'h02, 8'h03, 8'h04, 8'h05);
        idle_bits(3);
`ifdef CURSOR_RX_TIMEOUT_EN
        check_pulses("t6", 1, 0, 0, 1);
        check_fields("t6", 2'b10, 8'h03, 8'h04);
`else
        // Stale packet BTN=01 DX=A5 DY=02 CHK=03; 01^A5^02 = A6 so it fails the checksum.
        check_pulses("t6", 0, 0, 1, 0);
        check_fields("t6", 2'b10, 8'hFE, 8'h01);
`endif

        check("exclusive_pulses", overlap_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
